// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants and small helpers used across the MIPS core stages.
package wb_regfile_pkg;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        ZeroBit      = 1'b0;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;

  localparam int          RegNumWidth  = 5;
  localparam int          RegNum       = 32;

  localparam logic        ReadEnable   = 1'b1;
  localparam logic        ReadDisable  = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  typedef logic [RegNumWidth-1:0] regnum_t;

  // r0 is architecturally hardwired to zero.
  function automatic logic is_r0(input regnum_t rn);
    return (rn == '0);
  endfunction

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Two-read one-write register array with r0 hardwired to zero,
// same-cycle write-to-read bypass and synchronous full clear on reset.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic                    re1_i,
  input  logic [$clog2(NREG)-1:0] ra1_i,
  input  logic                    re2_i,
  input  logic [$clog2(NREG)-1:0] ra2_i,
  output logic [DW-1:0]           rd1_o,
  output logic [DW-1:0]           rd2_o
);

  localparam int AW = $clog2(NREG);

  logic [DW-1:0] regs_q [NREG];
  logic          wr_en;

  // The r0 and reset guards are repeated here so the array is safe on its own.
  assign wr_en = we_i && (waddr_i != '0) && !reset;

  // Resolve one read port: reset, disable and r0 force zero; a matching write bypasses.
  function automatic logic [DW-1:0] read_port(
    input logic          rst_now,
    input logic          re,
    input logic [AW-1:0] ra,
    input logic          wen,
    input logic [AW-1:0] wa,
    input logic [DW-1:0] wd,
    input logic [DW-1:0] mem_val
  );
    if (rst_now)         return '0;
    else if (!re)        return '0;
    else if (ra == '0)   return '0;
    else if (wen && (ra == wa)) return wd;
    else                 return mem_val;
  endfunction

  // Array update: synchronous clear of every entry on reset, single write otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read ports with same-cycle bypass.
  always_comb begin
    rd1_o = read_port(reset, re1_i, ra1_i, wr_en, waddr_i, wdata_i, regs_q[ra1_i]);
    rd2_o = read_port(reset, re2_i, ra2_i, wr_en, waddr_i, wdata_i, regs_q[ra2_i]);
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU or load data, commits it to the register file,
// drives the debug writeback trace and counts retired register writes.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          i_d1,
  input  logic [DW-1:0]          i_d2,
  input  logic [RegNumWidth-1:0] i_rn,
  input  logic                   i_write_regfile,
  input  logic                   i_mem_to_regfile,
  input  logic [31:0]            i_pc,
  input  logic                   i_re1,
  input  logic [RegNumWidth-1:0] i_ra1,
  input  logic                   i_re2,
  input  logic [RegNumWidth-1:0] i_ra2,
  output logic [DW-1:0]          o_rd1,
  output logic [DW-1:0]          o_rd2,
  output logic [31:0]            o_dbg_pc,
  output logic [3:0]             o_dbg_wen,
  output logic [RegNumWidth-1:0] o_dbg_wnum,
  output logic [DW-1:0]          o_dbg_wdata,
  output logic [31:0]            o_commit_cnt
);

  logic [DW-1:0] wdata;
  logic          we;
  logic [31:0]   commit_cnt_q;
  logic [31:0]   commit_cnt_d;

  // Writeback data select and effective write enable (r0 writes and reset cycles drop out).
  always_comb begin
    wdata = i_mem_to_regfile ? i_d2 : i_d1;
    we    = i_write_regfile && !is_r0(i_rn) && !reset;
  end

  regfile_2r1w #(
    .NREG (NREG),
    .DW   (DW)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we),
    .waddr_i (i_rn),
    .wdata_i (wdata),
    .re1_i   (i_re1),
    .ra1_i   (i_ra1),
    .re2_i   (i_re2),
    .ra2_i   (i_ra2),
    .rd1_o   (o_rd1),
    .rd2_o   (o_rd2)
  );

  // Debug trace mirrors the WB inputs and is blanked while reset is held.
  always_comb begin
    o_dbg_pc    = ZeroWord;
    o_dbg_wen   = 4'h0;
    o_dbg_wnum  = '0;
    o_dbg_wdata = '0;
    if (!reset) begin
      o_dbg_pc    = i_pc;
      o_dbg_wen   = {4{we}};
      o_dbg_wnum  = i_rn;
      o_dbg_wdata = wdata;
    end
  end

  // Next commit count: plain modulo-2^32 increment per effective write.
  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (we) begin
      commit_cnt_d = commit_cnt_q + 32'd1;
    end
  end

  // Commit counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_cnt_q <= ZeroWord;
    end else begin
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign o_commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, data select, bypass, r0 rule,
// mid-stream reset and counter wrap, with hand-computed expectations.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_d1, i_d2, i_pc;
  logic [4:0]  i_rn, i_ra1, i_ra2;
  logic        i_write_regfile, i_mem_to_regfile, i_re1, i_re2;
  logic [31:0] o_rd1, o_rd2, o_dbg_pc, o_dbg_wdata, o_commit_cnt;
  logic [3:0]  o_dbg_wen;
  logic [4:0]  o_dbg_wnum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk              (clk),
    .reset            (reset),
    .i_d1             (i_d1),
    .i_d2             (i_d2),
    .i_rn             (i_rn),
    .i_write_regfile  (i_write_regfile),
    .i_mem_to_regfile (i_mem_to_regfile),
    .i_pc             (i_pc),
    .i_re1            (i_re1),
    .i_ra1            (i_ra1),
    .i_re2            (i_re2),
    .i_ra2            (i_ra2),
    .o_rd1            (o_rd1),
    .o_rd2            (o_rd2),
    .o_dbg_pc         (o_dbg_pc),
    .o_dbg_wen        (o_dbg_wen),
    .o_dbg_wnum       (o_dbg_wnum),
    .o_dbg_wdata      (o_dbg_wdata),
    .o_commit_cnt     (o_commit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_d1 = '0; i_d2 = '0; i_rn = '0; i_pc = '0;
    i_write_regfile = 1'b0; i_mem_to_regfile = 1'b0;
    i_re1 = 1'b0; i_ra1 = '0; i_re2 = 1'b0; i_ra2 = '0;
  endtask

  task automatic present_write(input logic [4:0] rn, input logic [31:0] d1,
                               input logic [31:0] d2, input logic mem_to,
                               input logic [31:0] pc);
    i_rn = rn; i_d1 = d1; i_d2 = d2; i_mem_to_regfile = mem_to;
    i_pc = pc; i_write_regfile = 1'b1;
  endtask

  // Read every address on both ports and expect zero.
  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      i_re1 = 1'b1; i_ra1 = 5'(a);
      i_re2 = 1'b1; i_ra2 = 5'(31 - a);
      #1;
      check({tag, "_rd1"}, o_rd1, 32'h0);
      check({tag, "_rd2"}, o_rd2, 32'h0);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Reset held for two cycles; trace stays blank even with a write presented.
    @(negedge clk);
    present_write(5'd7, 32'hAAAA5555, 32'h0, 1'b0, 32'hBFC0_0000);
    i_re1 = 1'b1; i_ra1 = 5'd7;
    #1;
    check("rst_dbg_wen", {28'h0, o_dbg_wen}, 32'h0);
    check("rst_dbg_pc", o_dbg_pc, 32'h0);
    check("rst_dbg_wdata", o_dbg_wdata, 32'h0);
    check("rst_rd1", o_rd1, 32'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    check_all_zero("post_rst");
    check("post_rst_cnt", o_commit_cnt, 32'h0);
    check("post_rst_r7", o_rd1, 32'h0);

    // Data select: load data to r5, ALU result to r6.
    @(negedge clk);
    idle_inputs();
    present_write(5'd5, 32'h11111111, 32'h22222222, 1'b1, 32'hBFC0_0100);
    #1;
    check("mux1_wen", {28'h0, o_dbg_wen}, 32'hF);
    check("mux1_wnum", {27'h0, o_dbg_wnum}, 32'd5);
    check("mux1_wdata", o_dbg_wdata, 32'h22222222);
    check("mux1_pc", o_dbg_pc, 32'hBFC0_0100);
    @(negedge clk);
    present_write(5'd6, 32'h11111111, 32'h22222222, 1'b0, 32'hBFC0_0104);
    #1;
    check("mux2_wen", {28'h0, o_dbg_wen}, 32'hF);
    check("mux2_wnum", {27'h0, o_dbg_wnum}, 32'd6);
    check("mux2_wdata", o_dbg_wdata, 32'h11111111);
    @(negedge clk);
    idle_inputs();
    i_re1 = 1'b1; i_ra1 = 5'd5; i_re2 = 1'b1; i_ra2 = 5'd6;
    #1;
    check("mux_r5", o_rd1, 32'h22222222);
    check("mux_r6", o_rd2, 32'h11111111);
    check("mux_cnt", o_commit_cnt, 32'd2);
    check("bubble_wen", {28'h0, o_dbg_wen}, 32'h0);

    // Bubble cycle: no write, no count.
    @(negedge clk);
    #1;
    check("bubble_cnt", o_commit_cnt, 32'd2);

    // Bypass: both ports see the in-flight write; disabled port returns zero.
    @(negedge clk);
    present_write(5'd9, 32'hDEADBEEF, 32'h0, 1'b0, 32'hBFC0_0200);
    i_re1 = 1'b1; i_ra1 = 5'd9; i_re2 = 1'b1; i_ra2 = 5'd9;
    #1;
    check("byp_rd1", o_rd1, 32'hDEADBEEF);
    check("byp_rd2", o_rd2, 32'hDEADBEEF);
    i_re2 = 1'b0;
    #1;
    check("byp_rd2_dis", o_rd2, 32'h0);
    check("byp_rd1_keep", o_rd1, 32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    i_re1 = 1'b1; i_ra1 = 5'd9; i_re2 = 1'b1; i_ra2 = 5'd5;
    #1;
    check("byp_r9_arch", o_rd1, 32'hDEADBEEF);
    check("byp_r5_kept", o_rd2, 32'h22222222);
    check("byp_cnt", o_commit_cnt, 32'd3);

    // r0 rule: write dropped, read zero, no trace enable, no count.
    @(negedge clk);
    present_write(5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'hBFC0_0300);
    i_re1 = 1'b1; i_ra1 = 5'd0;
    #1;
    check("r0_rd1", o_rd1, 32'h0);
    check("r0_wen", {28'h0, o_dbg_wen}, 32'h0);
    check("r0_wnum", {27'h0, o_dbg_wnum}, 32'd0);
    @(negedge clk);
    idle_inputs();
    i_re1 = 1'b1; i_ra1 = 5'd0;
    #1;
    check("r0_later", o_rd1, 32'h0);
    check("r0_cnt", o_commit_cnt, 32'd3);

    // Fill r1..r31 with their index.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      idle_inputs();
      present_write(5'(r), 32'(r), 32'hFFFF_0000, 1'b0, 32'h0);
    end
    @(negedge clk);
    idle_inputs();
    i_re1 = 1'b1; i_ra1 = 5'd17; i_re2 = 1'b1; i_ra2 = 5'd31;
    #1;
    check("fill_r17", o_rd1, 32'd17);
    check("fill_r31", o_rd2, 32'd31);
    check("fill_cnt", o_commit_cnt, 32'd34);

    // Reset mid-stream while a write to r3 is presented.
    @(negedge clk);
    reset = 1'b1;
    present_write(5'd3, 32'h0000ABCD, 32'h0, 1'b0, 32'hBFC0_0400);
    i_re1 = 1'b1; i_ra1 = 5'd3;
    #1;
    check("mid_rst_rd1", o_rd1, 32'h0);
    check("mid_rst_wen", {28'h0, o_dbg_wen}, 32'h0);
    check("mid_rst_wnum", {27'h0, o_dbg_wnum}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("mid_rst");
    check("mid_rst_cnt", o_commit_cnt, 32'h0);
    i_re1 = 1'b1; i_ra1 = 5'd3;
    #1;
    check("mid_rst_r3", o_rd1, 32'h0);

    // Counter wrap: preload near the top, then two commits.
    @(negedge clk);
    force dut.commit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.commit_cnt_q;
    #1;
    check("wrap_preload", o_commit_cnt, 32'hFFFF_FFFE);
    present_write(5'd12, 32'h12, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    check("wrap_top", o_commit_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    idle_inputs();
    #1;
    check("wrap_zero", o_commit_cnt, 32'h0000_0000);
    i_re1 = 1'b1; i_ra1 = 5'd12;
    #1;
    check("wrap_r12", o_rd1, 32'h12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage and general-purpose register file of the 5-stage MIPS core.
- Consumes the MEM/WB pipeline register outputs: selects the writeback data (ALU result or load data) and commits it to the 32x32 register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Drives the NSCSCC debug writeback trace and a retired-write counter for performance monitoring.

Parameters:
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.
- DW, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- i_d1  in  DW  ALU/execute result from MEM/WB.
- i_d2  in  DW  memory load data from MEM/WB.
- i_rn  in  5  destination register number.
- i_write_regfile  in  1  writeback enable.
- i_mem_to_regfile  in  1  1 = write i_d2, 0 = write i_d1.
- i_pc  in  32  PC of the instruction in WB; used for trace only.
- i_re1  in  1  read port 1 enable.
- i_ra1  in  5  read port 1 address.
- i_re2  in  1  read port 2 enable.
- i_ra2  in  5  read port 2 address.
- o_rd1  out  DW  read port 1 data.
- o_rd2  out  DW  read port 2 data.
- o_dbg_pc  out  32  trace PC.
- o_dbg_wen  out  4  trace byte write enables.
- o_dbg_wnum  out  5  trace register number.
- o_dbg_wdata  out  DW  trace write data.
- o_commit_cnt  out  32  count of committed register writes.

Behaviour:
- Write data: wdata = i_mem_to_regfile ? i_d2 : i_d1. This path is combinational.
- Effective write enable: we = i_write_regfile & (i_rn != 0) & ~reset.
- Register update:
  - When we = 1, regs[i_rn] <= wdata at the rising edge.
  - The new value is architecturally visible from the next cycle.
  - Via bypass, it is also visible on the read ports in the same cycle.
- r0 is hardwired to zero:
  - Writes to r0 are dropped.
  - Reads of r0 always return 0, even when a write to r0 is presented.
- Read port k (k = 1, 2), combinational, in priority order:
  - reset = 1 -> 0.
  - i_rek = 0 -> 0.
  - i_rak = 0 -> 0.
  - we = 1 and i_rak == i_rn -> wdata (bypass).
  - otherwise -> regs[i_rak].
- Both ports may read the same address, and both may hit the bypass in the same cycle; each returns the same value independently.
- Reset:
  - Synchronous; all NREG registers clear to 0 and o_commit_cnt clears to 0 at the edge where reset = 1.
  - A write presented while reset = 1 is discarded.
  - If reset is asserted mid-stream, the register file is fully zeroed with no partial state.
- Debug trace (combinational from the WB inputs):
  - o_dbg_pc = i_pc.
  - o_dbg_wen = {4{we}}.
  - o_dbg_wnum = i_rn.
  - o_dbg_wdata = wdata.
  - All four are 0 while reset = 1.
- Commit counter:
  - Increments by 1 at each edge where we = 1; writes to r0 do not count.
  - Wraps modulo 2^32 (0xFFFFFFFF -> 0x00000000) with no saturation.
- Bubbles from MEM/WB arrive as all-zero inputs (i_write_regfile = 0). These produce no write, no count, and zero trace enables.
- Latency: write-to-architectural-state is 1 cycle; read is 0 cycles.

Decomposition:
- Shared defines package holds the constants used by the other pipeline stages:
  - ZeroWord (32'h0), ZeroBit, Stop/NoStop.
  - RegNumWidth (5), RegNum (32).
  - ReadEnable/WriteEnable.
- One natural sub-module: regfile_2r1w. It holds the array, r0 rule, bypass and reset clear.
- wb_regfile wraps regfile_2r1w with the data mux, trace outputs and commit counter.

Test Plan:
- Reset then read: hold reset 2 cycles, release, read all 32 addresses on both ports -> every o_rd = 0 and o_commit_cnt = 0.
- Mux select: write rn = 5 with d1 = 0x11111111, d2 = 0x22222222, mem_to = 1, then the same with mem_to = 0 to rn = 6 -> regs[5] = 0x22222222, regs[6] = 0x11111111, o_commit_cnt = 2, trace shows wen = 4'hF, wnum 5 then 6.
- Bypass: in one cycle write rn = 9 data 0xDEADBEEF while ra1 = ra2 = 9 -> o_rd1 = o_rd2 = 0xDEADBEEF in the same cycle; with re2 = 0, o_rd2 = 0.
- r0 rule: write rn = 0 data 0xFFFFFFFF while reading ra1 = 0 -> o_rd1 = 0, o_dbg_wen = 0, o_commit_cnt unchanged; a later read of r0 is 0.
- Reset mid-operation: fill r1..r31 with their index, assert reset for 1 cycle while presenting a write to r3 -> all reads 0 afterwards, counter 0, r3 = 0.
- Counter wrap: force 0xFFFFFFFF commits (or preload via a hierarchical deposit), then one more write -> o_commit_cnt = 0x00000000.
